// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer of predicted return targets with a
// single checkpoint for rollback after a branch mispredict.
module return_addr_stack #(
  parameter int DEPTH = 4,
  parameter int VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [VLEN-1:0]            data_i,
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_restore_i,
  output logic [VLEN-1:0]            data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   tos_q, tos_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ckpt_valid_q, ckpt_valid_d;
  logic [PW-1:0]   ckpt_tos_q;
  logic [CW-1:0]   ckpt_cnt_q;
  logic [VLEN-1:0] ckpt_data_q;

  logic            wr_en;
  logic [PW-1:0]   wr_addr;
  logic [VLEN-1:0] wr_data;
  logic            empty, full, restore_eff, save_eff;
  logic [VLEN-1:0] top_post;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == FULL_CNT);
  assign restore_eff = ckpt_restore_i & ckpt_valid_q;
  assign save_eff    = ckpt_save_i & ~flush_i & ~restore_eff;

  always_comb begin
    tos_d        = tos_q;
    cnt_d        = cnt_q;
    ckpt_valid_d = ckpt_valid_q;
    wr_en        = 1'b0;
    wr_addr      = tos_q;
    wr_data      = data_i;
    if (flush_i) begin
      tos_d        = '0;
      cnt_d        = '0;
      ckpt_valid_d = 1'b0;
    end else if (restore_eff) begin
      tos_d   = ckpt_tos_q;
      cnt_d   = ckpt_cnt_q;
      wr_en   = 1'b1;
      wr_addr = ckpt_tos_q;
      wr_data = ckpt_data_q;
    end else begin
      // Push+pop on a non-empty stack replaces the top in place.
      if (push_i && pop_i && !empty) begin
        wr_en = 1'b1;
      end else if (push_i) begin
        tos_d   = tos_q + PW'(1);
        wr_en   = 1'b1;
        wr_addr = tos_q + PW'(1);
        if (!full) cnt_d = cnt_q + CW'(1);
      end else if (pop_i && !empty) begin
        tos_d = tos_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
      if (ckpt_save_i) ckpt_valid_d = 1'b1;
    end
  end

  // Checkpoint sees the top entry as it will be after this cycle's write.
  assign top_post = (wr_en && (wr_addr == tos_d)) ? wr_data : mem_q[tos_d];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q        <= '0;
      cnt_q        <= '0;
      ckpt_valid_q <= 1'b0;
      ckpt_tos_q   <= '0;
      ckpt_cnt_q   <= '0;
      ckpt_data_q  <= '0;
    end else begin
      tos_q        <= tos_d;
      cnt_q        <= cnt_d;
      ckpt_valid_q <= ckpt_valid_d;
      if (save_eff) begin
        ckpt_tos_q  <= tos_d;
        ckpt_cnt_q  <= cnt_d;
        ckpt_data_q <= top_post;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign data_o     = empty ? '0 : mem_q[tos_q];
  assign valid_o    = ~empty;
  assign full_o     = full;
  assign count_o    = cnt_q;
  assign overflow_o = push_i & ~pop_i & full & ~flush_i & ~restore_eff;

endmodule

// File: tb/tb_return_addr_stack.sv
// Randomized and directed bench for return_addr_stack against a modulo-arithmetic
// reference model of the stack and its checkpoint.
module tb_return_addr_stack;

  localparam int DEPTH = 4;
  localparam int VLEN  = 64;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i, push_i, pop_i, ckpt_save_i, ckpt_restore_i;
  logic [VLEN-1:0] data_i;
  logic [VLEN-1:0] data_o;
  logic            valid_o, full_o, overflow_o;
  logic [CW-1:0]   count_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [VLEN-1:0] m_mem [DEPTH];
  int              m_tos, m_cnt;
  bit              m_cv;
  int              m_ct, m_cc;
  logic [VLEN-1:0] m_cd;
  logic            ovf_seen;

  return_addr_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i),
    .pop_i(pop_i), .data_i(data_i), .ckpt_save_i(ckpt_save_i),
    .ckpt_restore_i(ckpt_restore_i), .data_o(data_o), .valid_o(valid_o),
    .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_tos = 0; m_cnt = 0; m_cv = 0; m_ct = 0; m_cc = 0; m_cd = '0;
  endtask

  function automatic logic [VLEN-1:0] m_top();
    return (m_cnt == 0) ? '0 : m_mem[m_tos];
  endfunction

  task automatic model_step(input bit fl, input bit pu, input bit po,
                            input logic [VLEN-1:0] d, input bit sv, input bit rs);
    if (fl) begin
      m_tos = 0; m_cnt = 0; m_cv = 0;
    end else if (rs && m_cv) begin
      m_tos = m_ct; m_cnt = m_cc; m_mem[m_ct] = m_cd;
    end else begin
      if (pu && po && m_cnt > 0) begin
        m_mem[m_tos] = d;
      end else if (pu) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = d;
        if (m_cnt < DEPTH) m_cnt++;
      end else if (po && m_cnt > 0) begin
        m_tos = (m_tos + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
      if (sv) begin
        m_ct = m_tos; m_cc = m_cnt; m_cd = m_mem[m_tos]; m_cv = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_data"},  data_o,  m_top());
    check_eq({tag, "_count"}, VLEN'(count_o), VLEN'(m_cnt));
    check_eq({tag, "_valid"}, VLEN'(valid_o), VLEN'(m_cnt != 0));
    check_eq({tag, "_full"},  VLEN'(full_o),  VLEN'(m_cnt == DEPTH));
  endtask

  task automatic cycle(input bit fl, input bit pu, input bit po,
                       input logic [VLEN-1:0] d, input bit sv, input bit rs, input string tag);
    bit exp_ovf;
    @(negedge clk_i);
    flush_i = fl; push_i = pu; pop_i = po; data_i = d;
    ckpt_save_i = sv; ckpt_restore_i = rs;
    #1;
    exp_ovf = !fl && !(rs && m_cv) && pu && !po && (m_cnt == DEPTH);
    ovf_seen = overflow_o;
    check_eq({tag, "_ovf"}, VLEN'(overflow_o), VLEN'(exp_ovf));
    @(posedge clk_i);
    model_step(fl, pu, po, d, sv, rs);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    flush_i = 0; push_i = 0; pop_i = 0; data_i = '0;
    ckpt_save_i = 0; ckpt_restore_i = 0;
  endtask

  task automatic push(input logic [VLEN-1:0] d, input string tag);
    cycle(0, 1, 0, d, 0, 0, tag);
  endtask

  task automatic pop(input string tag);
    cycle(0, 0, 1, '0, 0, 0, tag);
  endtask

  task automatic flush(input string tag);
    cycle(1, 0, 0, '0, 0, 0, tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check_outputs(tag);
    check_eq({tag, "_ovf"}, VLEN'(overflow_o), '0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_ni = 1'b0;
    #12;
    check_outputs("reset");
    check_eq("reset_ovf", VLEN'(overflow_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic push/pop
    push('h100, "r33a"); push('h200, "r33b"); push('h300, "r33c");
    check_eq("r33_cnt", VLEN'(count_o), 3);
    check_eq("r33_top", data_o, 'h300);
    pop("r33d");
    check_eq("r33_pop_top", data_o, 'h200);
    check_eq("r33_pop_cnt", VLEN'(count_o), 2);

    // Overflow discards the oldest entry
    flush("r34f");
    for (int i = 0; i < 5; i++) push(VLEN'('hA + i), "r34p");
    check_eq("r34_ovf", VLEN'(ovf_seen), 1);
    check_eq("r34_full", VLEN'(full_o), 1);
    for (int i = 0; i < 4; i++) begin
      pop("r34q");
      if (i < 3) check_eq("r34_pop", data_o, VLEN'('hD - i));
    end
    check_eq("r34_valid", VLEN'(valid_o), 0);
    check_eq("r34_data", data_o, 0);

    // Pop on empty, push+pop on empty
    pop("r35a");
    check_eq("r35_cnt0", VLEN'(count_o), 0);
    cycle(0, 1, 1, 'h40, 0, 0, "r35b");
    check_eq("r35_cnt1", VLEN'(count_o), 1);
    check_eq("r35_top", data_o, 'h40);

    // Push+pop replaces top
    flush("r36f"); push('h10, "r36a"); push('h20, "r36b");
    cycle(0, 1, 1, 'h99, 0, 0, "r36c");
    check_eq("r36_cnt", VLEN'(count_o), 2);
    check_eq("r36_top", data_o, 'h99);
    pop("r36d");
    check_eq("r36_pop", data_o, 'h10);

    // Checkpoint save / restore
    flush("r37f"); push('h10, "r37a"); push('h20, "r37b");
    cycle(0, 0, 0, '0, 1, 0, "r37s");
    pop("r37c"); push('h77, "r37d");
    check_eq("r37_top", data_o, 'h77);
    cycle(0, 1, 0, 'h55, 0, 1, "r37r");
    check_eq("r37_cnt", VLEN'(count_o), 2);
    check_eq("r37_rtop", data_o, 'h20);

    // Flush invalidates the checkpoint
    flush("r38f"); push('h1, "r38a"); push('h2, "r38b"); push('h3, "r38c");
    cycle(0, 0, 0, '0, 1, 0, "r38s");
    flush("r38g");
    check_eq("r38_cnt", VLEN'(count_o), 0);
    check_eq("r38_valid", VLEN'(valid_o), 0);
    cycle(0, 0, 0, '0, 0, 1, "r38r");
    check_eq("r38_rcnt", VLEN'(count_o), 0);

    // Reset mid-operation drops a pending checkpoint
    push('h5, "rstA"); push('h6, "rstB");
    cycle(0, 0, 0, '0, 1, 0, "rstS");
    async_reset("rst_mid");
    cycle(0, 0, 0, '0, 0, 1, "rst_restore");
    check_eq("rst_rcnt", VLEN'(count_o), 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit fl, pu, po, sv, rs;
      logic [VLEN-1:0] d;
      fl = ($urandom_range(99) < 3);
      pu = ($urandom_range(99) < 50);
      po = ($urandom_range(99) < 40);
      sv = ($urandom_range(99) < 15);
      rs = ($urandom_range(99) < 10);
      d  = {$urandom, $urandom};
      cycle(fl, pu, po, d, sv, rs, "rnd");
      if (n % 500 == 499) async_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, >=2.
REQ-002 Parameter VLEN, default 64: return-address width in bits.
REQ-003 clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  empty the stack and invalidate the checkpoint.
REQ-006 push_i  in  1  push data_i (call retired by the branch unit).
REQ-007 pop_i  in  1  pop top entry (return predicted in decode).
REQ-008 data_i  in  VLEN  return address to push.
REQ-009 ckpt_save_i  in  1  snapshot the current stack state.
REQ-010 ckpt_restore_i  in  1  roll back to the last snapshot (mispredict).
REQ-011 data_o  out  VLEN  current top entry; 0 when empty.
REQ-012 valid_o  out  1  stack non-empty (count_o != 0).
REQ-013 full_o  out  1  count_o == DEPTH.
REQ-014 count_o  out  $clog2(DEPTH+1)  number of valid entries.
REQ-015 overflow_o  out  1  combinational; high when the current cycle's push discards the oldest entry.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH x VLEN with top pointer tos_q ($clog2(DEPTH) bits, wraps modulo DEPTH) and counter cnt_q; entries SHALL not be shifted.
REQ-017 data_o, valid_o, full_o and count_o SHALL be derived from registered state only; an operation is visible on the outputs in the cycle after its clock edge (latency 1).
REQ-018 Push only: tos <= tos+1 (wrap), entry[tos+1] <= data_i, cnt <= min(cnt+1, DEPTH).
REQ-019 Push when full: the oldest entry SHALL be overwritten, cnt stays DEPTH, overflow_o = 1 in that cycle.
REQ-020 Pop only with cnt>0: tos <= tos-1 (wrap), cnt <= cnt-1; the popped entry's value is not cleared.
REQ-021 Pop only with cnt==0: SHALL be ignored (no state change, no wrap of tos).
REQ-022 Push and pop in the same cycle with cnt>0: entry[tos] <= data_i, tos and cnt unchanged, overflow_o = 0.
REQ-023 Push and pop in the same cycle with cnt==0: treated as push only (cnt becomes 1).
REQ-024 ckpt_save_i SHALL capture {tos, cnt, entry[tos]} of the post-update state of the same cycle into the checkpoint register and set ckpt_valid.
REQ-025 ckpt_restore_i with ckpt_valid SHALL load tos and cnt from the checkpoint and rewrite entry[ckpt.tos] with the saved top value; push_i, pop_i and ckpt_save_i in that cycle SHALL be ignored.
REQ-026 ckpt_restore_i without ckpt_valid SHALL be ignored; push/pop in that cycle proceed normally.
REQ-027 Priority, highest first: flush_i, ckpt_restore_i, push/pop (+ckpt_save_i).
REQ-028 flush_i SHALL set cnt=0, tos=0, ckpt_valid=0; entry contents need not be cleared; push/pop/save in that cycle ignored.
REQ-029 Entries below the top overwritten after a save are not recovered by restore; this is accepted prediction loss, not an error.
REQ-030 data_o SHALL be 0 whenever cnt==0, independent of stale storage.

Reset
REQ-031 On rst_ni low, asynchronously: all entries 0, tos=0, cnt=0, ckpt register 0, ckpt_valid=0; hence data_o=0, valid_o=0, full_o=0, count_o=0, overflow_o=0 (absent push).
REQ-032 Reset asserted mid-operation SHALL discard all state, including a pending checkpoint, with no partial update on deassertion.

Verification
REQ-033 DEPTH=4: push 0x100,0x200,0x300 -> count_o=3, data_o=0x300; pop -> data_o=0x200, count_o=2.
REQ-034 DEPTH=4: push 0xA..0xE (5 pushes) -> overflow_o=1 on 5th push, full_o=1, four pops yield 0xE,0xD,0xC,0xB, then valid_o=0, data_o=0.
REQ-035 Empty stack, pop_i alone -> count_o stays 0; push_i+pop_i with data 0x40 -> count_o=1, data_o=0x40.
REQ-036 Stack {0x10,0x20}, push+pop with 0x99 -> count_o=2, data_o=0x99; pop -> data_o=0x10.
REQ-037 Stack {0x10,0x20}, ckpt_save_i; pop; push 0x77 -> data_o=0x77; ckpt_restore_i (with push_i high) -> count_o=2, data_o=0x20.
REQ-038 Stack of 3, ckpt saved, flush_i -> count_o=0, valid_o=0; subsequent ckpt_restore_i ignored, count_o stays 0.
